// File: rtl/mtx_mem_pkg.sv
// Shared types for the MTX512 SDRAM request path: grant owner, arbiter state, default address width.
// Pure definitions, no logic.
package mtx_mem_pkg;

  localparam int MEM_ADDR_W = 24;

  typedef enum logic [2:0] {
    G_NONE,
    G_REF,
    G_DL,
    G_VID,
    G_CPU
  } grant_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh deadline down-counter: loads INTERVAL-1, counts every cycle, holds at zero with due high.
// Reload takes effect on the next edge; due is combinational from the count.
module sdram_refresh_timer #(
  parameter int INTERVAL = 390
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic reload,
  output logic due
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= LOAD;
    end else if (reload) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign due = (cnt == '0);

endmodule

// File: rtl/sdram_arbiter.sv
// Serialises download, CPU and video accesses plus auto-refresh onto one SDRAM controller port.
// Grant one cycle after req in IDLE; ack one cycle after mem_ready; one RELEASE cycle between accesses.
module sdram_arbiter
  import mtx_mem_pkg::*;
#(
  parameter int ADDR_W           = MEM_ADDR_W,
  parameter int REFRESH_INTERVAL = 390
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_din,
  output logic              dl_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_dout,
  output logic              vid_ack,
  output logic              mem_req,
  output logic              mem_refresh,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready
);

  arb_state_t state;
  grant_t     grant;
  grant_t     winner;
  logic       last_cpu;
  logic       refresh_due;
  logic       reload;

  assign reload = (state == BUSY) && mem_ready && (grant == G_REF);

  sdram_refresh_timer #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .reload (reload),
    .due    (refresh_due)
  );

  // Video wins a tie unless it was the last of the pair served.
  always_comb begin
    winner = G_NONE;
    if (refresh_due) begin
      winner = G_REF;
    end else if (dl_req) begin
      winner = G_DL;
    end else if (vid_req && (!cpu_req || last_cpu)) begin
      winner = G_VID;
    end else if (cpu_req) begin
      winner = G_CPU;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= G_NONE;
      last_cpu    <= 1'b1;
      mem_req     <= 1'b0;
      mem_refresh <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      dl_ack      <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_dout    <= '0;
      vid_dout    <= '0;
    end else begin
      dl_ack  <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (winner != G_NONE) begin
            grant   <= winner;
            mem_req <= 1'b1;
            state   <= BUSY;
            case (winner)
              G_REF: begin
                mem_refresh <= 1'b1;
                mem_we      <= 1'b0;
              end
              G_DL: begin
                mem_addr <= dl_addr;
                mem_din  <= dl_din;
                mem_we   <= 1'b1;
              end
              G_VID: begin
                mem_addr <= vid_addr;
                mem_we   <= 1'b0;
                last_cpu <= 1'b0;
              end
              G_CPU: begin
                mem_addr <= cpu_addr;
                mem_din  <= cpu_din;
                mem_we   <= cpu_we;
                last_cpu <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req     <= 1'b0;
            mem_refresh <= 1'b0;
            state       <= RELEASE;
            case (grant)
              G_DL:  dl_ack <= 1'b1;
              G_VID: begin
                vid_ack  <= 1'b1;
                vid_dout <= mem_dout;
              end
              G_CPU: begin
                cpu_ack <= 1'b1;
                if (!mem_we) cpu_dout <= mem_dout;
              end
              default: ;
            endcase
          end
        end
        RELEASE: begin
          state <= IDLE;
          grant <= G_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port of the MTX512 core between three requesters: the ioctl ROM/tape download path, the Z80 CPU memory bus and the VDP/video fetch. It also schedules periodic auto-refresh. It sits between the requesters and the SDRAM controller's request/ready port. It sees only requests, never the SDRAM pins. It serialises every access through one registered state machine.

## Interface
Parameters:
- ADDR_W, 24, byte address width on all ports.
- REFRESH_INTERVAL, 390, clk_sys cycles between refresh deadlines; 390 is about 7.8 µs at 50 MHz.

Ports:
- clk_sys  in  1  system clock; all logic rises on it.
- reset_n  in  1  reset, asynchronous and active-low.
- dl_req / dl_addr / dl_din / dl_ack  in/in/in/out  1/ADDR_W/8/1  download writes; always a write.
- cpu_req / cpu_we / cpu_addr / cpu_din  in  1/1/ADDR_W/8  CPU access.
- cpu_dout / cpu_ack  out  8/1  CPU read data and completion.
- vid_req / vid_addr  in  1/ADDR_W  video read request; always a read.
- vid_dout / vid_ack  out  8/1  video read data and completion.
- mem_req / mem_refresh / mem_we  out  1/1/1  request to the SDRAM controller.
- mem_addr / mem_din  out  ADDR_W/8  address and write data to the SDRAM controller.
- mem_dout  in  8  read data; valid in the mem_ready cycle.
- mem_ready  in  1  one-cycle completion pulse from the SDRAM controller.

## Operation
- Handshake with requesters:
  - A requester raises req with addr, we and din stable.
  - It holds them until its ack pulses for exactly one cycle.
  - It drops req no later than the cycle after ack.
- FSM states: IDLE, BUSY, RELEASE.
- In IDLE, a grant is taken if any source is pending. Priority: refresh_due > dl > video/cpu.
  - Between video and cpu, round-robin on last_vc.
  - If both are pending, the one not served last wins.
  - If only one is pending, it wins regardless of last_vc.
- On grant:
  - mem_addr, mem_we and mem_din are registered from the winner.
  - mem_req is set to 1.
  - For refresh, mem_refresh=1, mem_we=0 and mem_addr holds its previous value.
  - The FSM goes to BUSY.
- BUSY:
  - mem_req stays high until mem_ready.
  - On mem_ready, a read latches mem_dout into the granted dout register. dout holds until that source's next read completes.
  - On mem_ready, mem_req and mem_refresh clear, the granted ack is set for one cycle, and the FSM goes to RELEASE.
  - A refresh produces no ack. It reloads the refresh counter.
- RELEASE: one cycle in which all req inputs are ignored. The FSM then returns to IDLE.
- Refresh timer:
  - Down-counter loaded with REFRESH_INTERVAL-1 and decremented every cycle, including during BUSY.
  - At 0 it holds, and refresh_due=1.
  - refresh_due clears on the reload at the refresh's mem_ready.
- Simultaneous events:
  - refresh_due rising while BUSY waits for IDLE and never preempts an access.
  - A req arriving in RELEASE is seen in the following IDLE cycle.
- Reset, including mid-access:
  - All outputs go to 0 immediately: mem_req, mem_refresh, mem_we, mem_addr, mem_din, all acks, all dout.
  - State goes to IDLE, counter to REFRESH_INTERVAL-1, and last_vc=cpu, so video wins the first tie.
  - No ack is issued for an aborted access. The SDRAM controller shares the same reset.

## Timing
- req high in IDLE at cycle N → mem_req=1 at N+1.
- mem_ready at cycle M ≥ N+1 → ack=1 and dout valid at M+1.
- RELEASE at M+1, IDLE at M+2. The earliest next grant is at M+2 and next mem_req at M+3.
- mem_ready seen outside BUSY is ignored.
- mem_req never rises in the cycle mem_ready is high.
- Worst-case wait for video or cpu with everything pending: one refresh, plus every pending dl access, plus one access of the other video/cpu source. Download traffic is unbounded by design, because the CPU is held in reset during download.

## Structure
- Shared package mtx_mem_pkg holds:
  - the grant_t enum: G_NONE, G_REF, G_DL, G_VID, G_CPU;
  - the arb_state_t enum: IDLE, BUSY, RELEASE;
  - the default ADDR_W constant.
- One sub-module, sdram_refresh_timer, contains the down-counter, the reload input and the due output.
- Arbitration and the FSM stay in sdram_arbiter.

## Test plan
- Reset, then idle with no requests → all outputs 0. mem_req with mem_refresh=1 rises exactly REFRESH_INTERVAL cycles after reset release. After mem_ready, the next refresh is due REFRESH_INTERVAL-1 cycles after the reload.
- CPU read of 0x001234, with mem_ready plus mem_dout=0xA5 two cycles after mem_req → mem_addr=0x001234 and mem_we=0. cpu_ack is a single pulse with cpu_dout=0xA5. cpu_dout still reads 0xA5 ten cycles later.
- vid_req and cpu_req raised together and held after each ack → served in order vid, cpu, vid, cpu, with no source granted twice in a row.
- dl write (0x000100, 0x3C) pending together with cpu_req → dl granted first with mem_we=1 and mem_din=0x3C, then cpu. cpu_dout is unchanged by the dl access.
- Refresh becomes due while a video access is BUSY, with dl_req also pending → the video access completes. Refresh is granted next, then dl.
- reset_n driven low while BUSY and mem_req=1 → mem_req and all acks are 0 in the same cycle, and no ack appears after reset is released.
